// File: rtl/packet_types.sv
// Flit framing types and ejection FSM state shared by the NoC ejection path.
package packet_types;

  localparam int FLIT_TYPE_WIDTH = 2;

  typedef enum logic [1:0] {
    HEAD     = 2'b00,
    BODY     = 2'b01,
    TAIL     = 2'b10,
    HEADTAIL = 2'b11
  } flit_type_e;

  typedef enum logic {
    IDLE   = 1'b0,
    IN_PKT = 1'b1
  } eject_state_e;

  // Caller passes the top FLIT_TYPE_WIDTH bits of the flit.
  function automatic flit_type_e flit_type_of(input logic [FLIT_TYPE_WIDTH-1:0] type_bits);
    return flit_type_e'(type_bits);
  endfunction

  // TAIL and HEADTAIL both close a packet.
  function automatic logic is_packet_end(input flit_type_e ft);
    return (ft == TAIL) || (ft == HEADTAIL);
  endfunction

endpackage

// File: rtl/noc_flit_fifo.sv
// Show-ahead flit FIFO: array storage, wrapping pointers and a registered occupancy count.
module noc_flit_fifo #(
  parameter int WIDTH = 34,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;

  // Storage carries no reset so it maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign full      = (count == (AW+1)'(DEPTH));
  assign empty     = (count == '0);
  // Head entry is forced to zero while empty so stale data never leaks out.
  assign rd_data   = empty ? '0 : mem[rd_ptr];
  assign occupancy = count;

endmodule

// File: rtl/noc_eject_flit_buffer.sv
// Ejection flit buffer: credit-returning show-ahead FIFO with input framing checks.
// Optional popped flit/packet counters are built when NOC_EJECT_STATS_EN is defined.
module noc_eject_flit_buffer
  import packet_types::*;
#(
  parameter int FLIT_WIDTH = 34,
  parameter int DEPTH      = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_flit_valid,
  input  logic [FLIT_WIDTH-1:0]      i_flit,
  output logic                       o_credit_return,
  output logic                       o_flit_valid,
  output logic [FLIT_WIDTH-1:0]      o_flit,
  input  logic                       i_flit_ready,
  output logic [$clog2(DEPTH):0]     o_occupancy,
  output logic                       o_framing_error,
  output logic                       o_overflow,
`ifdef NOC_EJECT_STATS_EN
  output logic [31:0]                o_flit_count,
  output logic [31:0]                o_packet_count,
`endif
  input  logic                       i_clear_error
);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("noc_eject_flit_buffer: DEPTH must be a power of 2 and >= 2");
  end

  logic         full;
  logic         empty;
  logic         push;
  logic         pop;
  logic         drop;
  logic         frame_err;
  flit_type_e   in_type;
  eject_state_e state_reg;
  eject_state_e state_next;

  assign in_type      = flit_type_of(i_flit[FLIT_WIDTH-1 -: FLIT_TYPE_WIDTH]);
  assign o_flit_valid = !empty;
  assign pop          = !empty && i_flit_ready;
  // A pop in the same cycle frees the slot, so a full buffer can still accept.
  assign push         = i_flit_valid && (!full || pop);
  assign drop         = i_flit_valid && full && !pop;

  noc_flit_fifo #(
    .WIDTH (FLIT_WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .wr_data   (i_flit),
    .pop       (pop),
    .rd_data   (o_flit),
    .full      (full),
    .empty     (empty),
    .occupancy (o_occupancy)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Only accepted flits advance the framing state; dropped ones are invisible.
  always_comb begin
    state_next = state_reg;
    frame_err  = 1'b0;
    if (push) begin
      case (state_reg)
        IDLE: begin
          case (in_type)
            HEAD:     state_next = IN_PKT;
            HEADTAIL: state_next = IDLE;
            default:  frame_err  = 1'b1;
          endcase
        end
        IN_PKT: begin
          case (in_type)
            BODY:     state_next = IN_PKT;
            TAIL:     state_next = IDLE;
            HEAD:     frame_err  = 1'b1;
            default: begin
              frame_err  = 1'b1;
              state_next = IDLE;
            end
          endcase
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // A new event in the same cycle as a clear keeps the flag set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_credit_return <= 1'b0;
      o_framing_error <= 1'b0;
      o_overflow      <= 1'b0;
    end else begin
      o_credit_return <= pop;
      if (frame_err) begin
        o_framing_error <= 1'b1;
      end else if (i_clear_error) begin
        o_framing_error <= 1'b0;
      end
      if (drop) begin
        o_overflow <= 1'b1;
      end else if (i_clear_error) begin
        o_overflow <= 1'b0;
      end
    end
  end

`ifdef NOC_EJECT_STATS_EN
  flit_type_e out_type;
  assign out_type = flit_type_of(o_flit[FLIT_WIDTH-1 -: FLIT_TYPE_WIDTH]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_flit_count   <= '0;
      o_packet_count <= '0;
    end else if (pop) begin
      o_flit_count <= o_flit_count + 32'd1;
      if (is_packet_end(out_type)) begin
        o_packet_count <= o_packet_count + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_noc_eject_flit_buffer.sv
// Directed, table-driven bench for noc_eject_flit_buffer (DEPTH 8, 34-bit flits).
module tb_noc_eject_flit_buffer;
  import packet_types::*;

  localparam int FW = 34;
  localparam int DP = 8;

  logic          clk;
  logic          rst;
  logic          flit_valid_in;
  logic [FW-1:0] flit_in;
  logic          credit_return;
  logic          flit_valid_out;
  logic [FW-1:0] flit_out;
  logic          flit_ready;
  logic [3:0]    occupancy;
  logic          framing_error;
  logic          overflow;
  logic          clear_error;
`ifdef NOC_EJECT_STATS_EN
  logic [31:0]   flit_count;
  logic [31:0]   packet_count;
`endif

  int checks;
  int failures;

  noc_eject_flit_buffer #(.FLIT_WIDTH(FW), .DEPTH(DP)) dut (
    .clk             (clk),
    .rst             (rst),
    .i_flit_valid    (flit_valid_in),
    .i_flit          (flit_in),
    .o_credit_return (credit_return),
    .o_flit_valid    (flit_valid_out),
    .o_flit          (flit_out),
    .i_flit_ready    (flit_ready),
    .o_occupancy     (occupancy),
    .o_framing_error (framing_error),
    .o_overflow      (overflow),
`ifdef NOC_EJECT_STATS_EN
    .o_flit_count    (flit_count),
    .o_packet_count  (packet_count),
`endif
    .i_clear_error   (clear_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          v;
    logic [FW-1:0] flit;
    logic          r;
    logic          clr;
    logic          ev;
    logic [FW-1:0] ef;
    logic          ec;
    logic [3:0]    eo;
    logic          efe;
    logic          eov;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [FW-1:0] mk(input flit_type_e t, input logic [31:0] p);
    return {t, p};
  endfunction

  task automatic add(input logic v, input logic [FW-1:0] flit, input logic r, input logic clr,
                     input logic ev, input logic [FW-1:0] ef, input logic ec, input int eo,
                     input logic efe, input logic eov);
    vec_t e;
    e.v = v; e.flit = flit; e.r = r; e.clr = clr;
    e.ev = ev; e.ef = ef; e.ec = ec; e.eo = 4'(eo); e.efe = efe; e.eov = eov;
    vecs.push_back(e);
  endtask

  task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic drive(input logic v, input logic [FW-1:0] flit, input logic r, input logic clr);
    flit_valid_in = v;
    flit_in       = flit;
    flit_ready    = r;
    clear_error   = clr;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic build_table();
    flit_type_e t;
    // 1: single HEADTAIL with ready held high
    add(1, mk(HEADTAIL, 32'h1234), 1, 0, 1, mk(HEADTAIL, 32'h1234), 0, 1, 0, 0);
    add(0, '0, 1, 0, 0, '0, 1, 0, 0, 0);
    add(0, '0, 1, 0, 0, '0, 0, 0, 0, 0);
    // 2: fill with an 8-flit packet, then drain in order
    for (int i = 0; i < 8; i++) begin
      t = (i == 0) ? HEAD : (i == 7) ? TAIL : BODY;
      add(1, mk(t, 32'h100 + i), 0, 0, 1, mk(HEAD, 32'h100), 0, i + 1, 0, 0);
    end
    for (int j = 1; j <= 8; j++) begin
      t = (j == 7) ? TAIL : BODY;
      add(0, '0, 1, 0, (j < 8), mk(t, 32'h100 + j), 1, 8 - j, 0, 0);
    end
    add(0, '0, 0, 0, 0, '0, 0, 0, 0, 0);
    // 3: overflow at full, clear, then push with same-cycle pop
    for (int i = 0; i < 8; i++) begin
      t = (i == 0) ? HEAD : BODY;
      add(1, mk(t, 32'h200 + i), 0, 0, 1, mk(HEAD, 32'h200), 0, i + 1, 0, 0);
    end
    add(1, mk(BODY, 32'h2FF), 0, 0, 1, mk(HEAD, 32'h200), 0, 8, 0, 1);
    add(0, '0, 0, 1, 1, mk(HEAD, 32'h200), 0, 8, 0, 0);
    add(1, mk(BODY, 32'h208), 1, 0, 1, mk(BODY, 32'h201), 1, 8, 0, 0);
    for (int j = 1; j <= 8; j++) begin
      add(0, '0, 1, 0, (j < 8), mk(BODY, 32'h201 + j), 1, 8 - j, 0, 0);
    end
    add(0, '0, 0, 0, 0, '0, 0, 0, 0, 0);
    add(1, mk(TAIL, 32'h209), 0, 0, 1, mk(TAIL, 32'h209), 0, 1, 0, 0);
    add(0, '0, 1, 0, 0, '0, 1, 0, 0, 0);
    // 4: framing errors, clear, and clear losing to a new error
    add(1, mk(BODY, 32'h300), 0, 0, 1, mk(BODY, 32'h300), 0, 1, 1, 0);
    add(0, '0, 1, 1, 0, '0, 1, 0, 0, 0);
    add(1, mk(HEAD, 32'h301), 1, 0, 1, mk(HEAD, 32'h301), 0, 1, 0, 0);
    add(1, mk(HEAD, 32'h302), 1, 1, 1, mk(HEAD, 32'h302), 1, 1, 1, 0);
    add(0, '0, 1, 1, 0, '0, 1, 0, 0, 0);
    add(1, mk(TAIL, 32'h303), 0, 0, 1, mk(TAIL, 32'h303), 0, 1, 0, 0);
    add(0, '0, 1, 0, 0, '0, 1, 0, 0, 0);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    drive(0, '0, 0, 0);
    build_table();
    step();
    step();
    check("reset_valid", 64'(flit_valid_out), 64'd0);
    check("reset_flit", 64'(flit_out), 64'd0);
    check("reset_credit", 64'(credit_return), 64'd0);
    check("reset_occ", 64'(occupancy), 64'd0);
    check("reset_ferr", 64'(framing_error), 64'd0);
    check("reset_ovf", 64'(overflow), 64'd0);
    rst = 1'b0;

    foreach (vecs[k]) begin
      drive(vecs[k].v, vecs[k].flit, vecs[k].r, vecs[k].clr);
      step();
      $display("vec %0d: v=%0b flit=%0h r=%0b clr=%0b -> valid=%0b flit=%0h credit=%0b occ=%0d ferr=%0b ovf=%0b",
               k, vecs[k].v, vecs[k].flit, vecs[k].r, vecs[k].clr,
               flit_valid_out, flit_out, credit_return, occupancy, framing_error, overflow);
      check($sformatf("v%0d_valid", k), 64'(flit_valid_out), 64'(vecs[k].ev));
      if (vecs[k].ev) check($sformatf("v%0d_flit", k), 64'(flit_out), 64'(vecs[k].ef));
      check($sformatf("v%0d_credit", k), 64'(credit_return), 64'(vecs[k].ec));
      check($sformatf("v%0d_occ", k), 64'(occupancy), 64'(vecs[k].eo));
      check($sformatf("v%0d_ferr", k), 64'(framing_error), 64'(vecs[k].efe));
      check($sformatf("v%0d_ovf", k), 64'(overflow), 64'(vecs[k].eov));
    end

    // 5: asynchronous reset with HEAD,BODY stored
    drive(1, mk(HEAD, 32'h400), 0, 0);
    step();
    drive(1, mk(BODY, 32'h401), 0, 0);
    step();
    drive(0, '0, 1, 0);
    check("mid_occ", 64'(occupancy), 64'd2);
    #2 rst = 1'b1;
    #1;
    $display("async reset: valid=%0b occ=%0d credit=%0b", flit_valid_out, occupancy, credit_return);
    check("arst_occ", 64'(occupancy), 64'd0);
    check("arst_valid", 64'(flit_valid_out), 64'd0);
    check("arst_credit", 64'(credit_return), 64'd0);
    step();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("arst_nocredit%0d", i), 64'(credit_return), 64'd0);
    end
    drive(1, mk(HEAD, 32'h402), 0, 0);
    step();
    $display("post-reset HEAD: occ=%0d ferr=%0b", occupancy, framing_error);
    check("arst_head_ferr", 64'(framing_error), 64'd0);
    check("arst_head_occ", 64'(occupancy), 64'd1);
    check("arst_head_flit", 64'(flit_out), 64'(mk(HEAD, 32'h402)));
    drive(0, '0, 1, 0);
    step();
    check("arst_drain_credit", 64'(credit_return), 64'd1);

`ifdef NOC_EJECT_STATS_EN
    // 6: three packets through with ready high
    rst = 1'b1;
    step();
    rst = 1'b0;
    drive(1, mk(HEADTAIL, 32'h500), 1, 0); step();
    drive(1, mk(HEAD, 32'h501), 1, 0);     step();
    drive(1, mk(TAIL, 32'h502), 1, 0);     step();
    drive(1, mk(HEAD, 32'h503), 1, 0);     step();
    drive(1, mk(BODY, 32'h504), 1, 0);     step();
    drive(1, mk(TAIL, 32'h505), 1, 0);     step();
    drive(0, '0, 1, 0);
    for (int i = 0; i < 3; i++) step();
    $display("stats: flits=%0d packets=%0d ferr=%0b", flit_count, packet_count, framing_error);
    check("stats_flits", 64'(flit_count), 64'd6);
    check("stats_packets", 64'(packet_count), 64'd3);
    check("stats_ferr", 64'(framing_error), 64'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
